// File: rtl/page_clean_out_if.sv
// rtl/page_clean_out_if.sv - BRAM read/zero-fill port and 512-bit output beat stream for page_clean_out
interface page_clean_out_if #(
  parameter int NUM_RAM    = 16,
  parameter int RAM_W      = 32,
  parameter int RAM_ADDR_W = 9
);
  localparam int LINE_W = NUM_RAM * RAM_W;
  localparam int KEEP_W = LINE_W / 8;

  logic                  ram_rd_en;
  logic [RAM_ADDR_W-1:0] ram_rd_addr;
  logic [LINE_W-1:0]     ram_rd_data;
  logic                  ram_we;
  logic [RAM_ADDR_W-1:0] ram_wr_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [LINE_W-1:0]     out_data;
  logic [KEEP_W-1:0]     out_keep;
  logic                  out_last;

  modport master (
    output ram_rd_en, ram_rd_addr, ram_we, ram_wr_addr,
    output out_valid, out_data, out_keep, out_last,
    input  ram_rd_data, out_ready
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, ram_we, ram_wr_addr,
    input  out_valid, out_data, out_keep, out_last,
    output ram_rd_data, out_ready
  );
endinterface

// File: rtl/page_clean_out.sv
// rtl/page_clean_out.sv - drains a finished page from the BRAM banks into a 512-bit beat stream
// Optional macro CLEAN_OUT_ZERO_FILL_EN: zero each line RD_LAT cycles after it is read.
module page_clean_out #(
  parameter int NUM_RAM    = 16,
  parameter int RAM_W      = 32,
  parameter int RAM_ADDR_W = 9,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             page_finish,
  input  logic [31:0]      page_len,
  output logic             cl_finish,
  page_clean_out_if.master bus
);
  localparam int LINE_W    = NUM_RAM * RAM_W;
  localparam int KEEP_W    = LINE_W / 8;
  localparam int BYTE_SH   = $clog2(KEEP_W);
  localparam int LCNT_W    = RAM_ADDR_W + 1;
  localparam int MAX_LINES = 1 << RAM_ADDR_W;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] DRAIN   = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] WAITLOW = 3'd4;

  logic [2:0]        state;
  logic [LCNT_W-1:0] n_lines;
  logic [LCNT_W-1:0] rd_cnt;
  logic [LCNT_W-1:0] beat_cnt;
  logic [KEEP_W-1:0] last_keep;
  logic [RD_LAT-1:0] rd_sr;
  logic [LINE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [OCC_W-1:0]  occ;
  logic              rd_en;
  logic              push;
  logic              pop;
  logic              valid;
  logic              is_last;
  logic              credit_ok;
  logic [7:0]        used;

  logic [32:0]        len_ext;
  logic               len_over;
  logic [BYTE_SH-1:0] rem;
  logic [LCNT_W-1:0]  n_calc;
  logic [KEEP_W-1:0]  keep_calc;

  // Oversized pages clamp to a full bank, whose last line is then completely valid.
  always_comb begin
    len_ext   = {1'b0, page_len} + 33'(KEEP_W - 1);
    len_over  = page_len > 32'(MAX_LINES * KEEP_W);
    rem       = page_len[BYTE_SH-1:0];
    n_calc    = len_over ? LCNT_W'(MAX_LINES) : LCNT_W'(len_ext >> BYTE_SH);
    keep_calc = '1;
    if (!len_over && rem != '0) begin
      for (int i = 0; i < KEEP_W; i++) begin
        keep_calc[i] = (i < int'(rem));
      end
    end
  end

  // Reads still in flight already own a FIFO slot.
  always_comb begin
    used = 8'(occ);
    for (int i = 0; i < RD_LAT; i++) begin
      used = used + 8'(rd_sr[i]);
    end
  end

  assign credit_ok = used < 8'(FIFO_DEPTH);
  assign rd_en     = (state == READ) && credit_ok;
  assign push      = rd_sr[RD_LAT-1];
  assign valid     = occ != '0;
  assign pop       = valid && bus.out_ready;
  assign is_last   = beat_cnt == n_lines - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_lines   <= '0;
      rd_cnt    <= '0;
      beat_cnt  <= '0;
      last_keep <= '0;
    end else begin
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (page_finish) begin
            if (page_len == 32'd0) begin
              state <= DONE;
            end else begin
              n_lines   <= n_calc;
              last_keep <= keep_calc;
              rd_cnt    <= '0;
              beat_cnt  <= '0;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == n_lines - 1'b1) state <= DRAIN;
          end
        end
        DRAIN:   if (pop && is_last) state <= DONE;
        DONE:    state <= WAITLOW;
        WAITLOW: if (!page_finish) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr <= '0;
    end else begin
      rd_sr[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_sr[i] <= rd_sr[i-1];
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= bus.ram_rd_data;
  end

  assign bus.out_valid   = valid;
  assign bus.out_data    = valid ? fifo_mem[rptr] : '0;
  assign bus.out_last    = valid && is_last;
  assign bus.out_keep    = !valid ? '0 : (is_last ? last_keep : '1);
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_cnt[RAM_ADDR_W-1:0];
  assign cl_finish       = state == DONE;

`ifdef CLEAN_OUT_ZERO_FILL_EN
  logic [RAM_ADDR_W-1:0] wa_pipe [RD_LAT];

  // Address travels alongside the read so the zero write lands with the data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) wa_pipe[i] <= '0;
    end else begin
      wa_pipe[0] <= bus.ram_rd_addr;
      for (int i = 1; i < RD_LAT; i++) wa_pipe[i] <= wa_pipe[i-1];
    end
  end

  assign bus.ram_we      = rd_sr[RD_LAT-1];
  assign bus.ram_wr_addr = wa_pipe[RD_LAT-1];
`else
  assign bus.ram_we      = 1'b0;
  assign bus.ram_wr_addr = '0;
`endif
endmodule

// File: tb/tb_page_clean_out.sv
// tb/tb_page_clean_out.sv - scoreboard bench for page_clean_out with a BRAM model and random backpressure
module tb_page_clean_out;
  localparam int NUM_RAM    = 16;
  localparam int RAM_W      = 32;
  localparam int RAM_ADDR_W = 9;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_LINES  = 512;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        page_finish = 1'b0;
  logic [31:0] page_len = '0;
  logic        cl_finish;

  page_clean_out_if #(.NUM_RAM(NUM_RAM), .RAM_W(RAM_W), .RAM_ADDR_W(RAM_ADDR_W)) bus ();

  page_clean_out #(
    .NUM_RAM(NUM_RAM), .RAM_W(RAM_W), .RAM_ADDR_W(RAM_ADDR_W),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .page_finish(page_finish), .page_len(page_len),
    .cl_finish(cl_finish), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [511:0] mem [MAX_LINES];
  logic [511:0] p1, p2;
  logic         fill_req = 1'b0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < MAX_LINES; i++)
        for (int w = 0; w < 16; w++) mem[i][w*32 +: 32] <= $urandom;
    end else if (bus.ram_we) begin
      mem[bus.ram_wr_addr] <= '0;
    end
    if (bus.ram_rd_en) p1 <= mem[bus.ram_rd_addr];
    p2 <= p1;
  end
  assign bus.ram_rd_data = p2;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  beat_t exp_q[$];
  int    exp_wr_q[$];
  int    exp_rd_addr = 0;
  int    reads = 0;
  int    pops = 0;
  int    we_cnt = 0;
  int    cl_count = 0;
  int    first_valid_cyc = -1;
  int    cl_cyc = -1;
  int    t_edge = 0;
  int    ready_mode = 0;
  logic  prev_hold = 1'b0;
  logic [511:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, prev_data);
      end
      if (bus.ram_rd_en) begin
        chk("rd_addr", bus.ram_rd_addr, exp_rd_addr);
        exp_wr_q.push_back(exp_rd_addr);
        exp_rd_addr++;
        reads++;
        chk("credit", (reads - pops) <= FIFO_DEPTH, 1);
      end
      if (bus.ram_we) begin
        we_cnt++;
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected: actual=%0d required=none", bus.ram_wr_addr);
        end else begin
          chk("wr_addr", bus.ram_wr_addr, exp_wr_q.pop_front());
        end
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: actual=%0h required=none", bus.out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", bus.out_data, e.data);
          chk("beat_keep", bus.out_keep, e.keep);
          chk("beat_last", bus.out_last, e.last);
        end
      end
      if (cl_finish) begin
        cl_count++;
        cl_cyc = cyc;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Expected beats come from the byte-level rule: byte k of beat i is valid iff i*64+k < length.
  task automatic start_page(input int len, input int mode);
    int eff;
    int n;
    ready_mode = mode;
    @(posedge clk); #1 fill_req = 1'b1;
    @(posedge clk); #1 fill_req = 1'b0;
    eff = (len > MAX_LINES * 64) ? MAX_LINES * 64 : len;
    n = (eff + 63) / 64;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = mem[i];
      for (int k = 0; k < 64; k++) b.keep[k] = (i * 64 + k < eff);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    exp_wr_q.delete();
    exp_rd_addr = 0; reads = 0; pops = 0; we_cnt = 0;
    first_valid_cyc = -1; cl_cyc = -1;
    page_len = 32'(len);
    page_finish = 1'b1;
    t_edge = cyc + 1;
  endtask

  task automatic run_page(input int len, input int mode, input bit timing, input int hold);
    int c0;
    int n;
    n = ((len > MAX_LINES * 64 ? MAX_LINES * 64 : len) + 63) / 64;
    c0 = cl_count;
    start_page(len, mode);
    for (int i = 0; i < hold; i++) @(posedge clk);
    #1 page_finish = 1'b0;
    for (int i = 0; i < 8000 && cl_count == c0; i++) @(posedge clk);
    chk("cl_seen", cl_count != c0, 1);
    repeat (4) @(posedge clk);
    chk("cl_once", cl_count - c0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("read_count", reads, n);
`ifdef CLEAN_OUT_ZERO_FILL_EN
    chk("we_count", we_cnt, n);
`else
    chk("we_count", we_cnt, 0);
`endif
    if (timing) begin
      chk("first_valid_cyc", first_valid_cyc, (n == 0) ? -1 : t_edge + 3);
      chk("cl_cyc", cl_cyc, (n == 0) ? t_edge : t_edge + n + 3);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_keep"}, bus.out_keep, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_rd_en"}, bus.ram_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.ram_rd_addr, 0);
    chk({tag, "_we"}, bus.ram_we, 0);
    chk({tag, "_wr_addr"}, bus.ram_wr_addr, 0);
    chk({tag, "_cl_finish"}, cl_finish, 0);
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    run_page(256, 0, 1'b1, 2);
    run_page(100, 2, 1'b0, 1);
    run_page(1024, 1, 1'b0, 4);
    run_page(0, 0, 1'b1, 3);
    run_page(64, 0, 1'b1, 1);
    run_page(40000, 0, 1'b1, 2);
    for (int r = 0; r < 6; r++) begin
      int m;
      m = $urandom_range(0, 2);
      run_page($urandom_range(1, 3000), m, m == 0, $urandom_range(1, 20));
    end

    c0 = cl_count;
    start_page(512, 0);
    for (int i = 0; i < 100 && pops < 2; i++) @(posedge clk);
    chk("abort_reached_beat3", pops >= 2, 1);
    #1 rst = 1'b1;
    page_finish = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("abort");
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_wr_q.delete();
    repeat (5) @(posedge clk);
    chk("abort_no_cl", cl_count - c0, 0);
    run_page(256, 0, 1'b1, 2);

`ifdef CLEAN_OUT_ZERO_FILL_EN
    run_page(128, 0, 1'b1, 2);
    chk("zf_line0", mem[0], 0);
    chk("zf_line1", mem[1], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/page_clean_out.md
# page_clean_out

Drains a decompressed page from the 16 history/output BRAM banks and streams it out once the decompression controller reports the page complete. It sits after the controller. It consumes `page_finish`, reads every bank line holding page data, and emits 512-bit beats under valid/ready backpressure. When the last beat has been accepted, it pulses `cl_finish` back to the controller. This closes the page handshake and releases the controller to accept the next page.

## Interface
Parameters:
- `NUM_RAM`, 16, number of BRAM banks read in parallel; one line = one address across all banks.
- `RAM_W`, 32, data width per bank in bits; line width = `NUM_RAM*RAM_W` = 512.
- `RAM_ADDR_W`, 9, bank address width; max page = 2^9 lines = 32 KiB.
- `RD_LAT`, 2, BRAM read latency in cycles; fixed, no valid returned by RAM.
- `FIFO_DEPTH`, 4, output skid FIFO depth in lines; must be >= `RD_LAT+2`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `page_finish`  in  1  level from controller: page fully decompressed into BRAMs.
- `page_len`  in  32  page byte count; valid whenever `page_finish` is high.
- `cl_finish`  out  1  one-cycle pulse: page fully streamed out.
- `ram_rd_en`  out  1  read strobe to all banks.
- `ram_rd_addr`  out  `RAM_ADDR_W`  line address to all banks.
- `ram_rd_data`  in  `NUM_RAM*RAM_W`  concatenated bank data, bank 0 in LSBs, valid `RD_LAT` cycles after `ram_rd_en`.
- `ram_we`  out  1  write strobe to all banks (zero-fill only).
- `ram_wr_addr`  out  `RAM_ADDR_W`  write line address (zero-fill only).
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  512  beat; byte 0 in bits [7:0].
- `out_keep`  out  64  byte-valid mask; all ones except on the final beat.
- `out_last`  out  1  final beat of page.

## Operation
- Reset values: all outputs 0. The state returns to IDLE, the FIFO and in-flight counters are cleared, and `ram_rd_addr`/`ram_wr_addr` = 0.
- Line count `n_lines = ceil(page_len/64)`, computed as `(page_len+63)>>6`. If `page_len > 2^RAM_ADDR_W*64`, it is clamped to the maximum page (2^RAM_ADDR_W lines, `out_keep` all ones on last).
- Final-beat keep: `r = page_len[5:0]`. If `r == 0`, keep = all ones; otherwise keep = `(1<<r)-1`.
- States:
  - IDLE: waits for `page_finish`. If `page_len == 0`, go to DONE. Otherwise latch `n_lines` and keep, then go to READ.
  - READ: issues one read per cycle while credit is available. Credit = FIFO occupancy + in-flight reads < `FIFO_DEPTH`. The address increments from 0. After issuing line `n_lines-1`, go to DRAIN.
  - DRAIN: no reads are issued. After the last beat handshakes, go to DONE.
  - DONE: `cl_finish` = 1 for exactly this cycle, then go to WAITLOW.
  - WAITLOW: waits for `page_finish` = 0, then goes to IDLE. This prevents retriggering while the controller is still dropping its level.
- In-flight tracking: a `RD_LAT`-deep shift register of `ram_rd_en`. Its output writes `ram_rd_data` into the FIFO.
- The FIFO head drives `out_data`. A beat counter marks `out_last` on beat `n_lines-1`.
- `out_valid`, once asserted, holds with stable data until `out_ready`.
- A simultaneous FIFO write and read in one cycle leaves occupancy unchanged. The FIFO never overflows, which the credit rule guarantees.
- `page_finish` dropping mid-page is ignored; the page completes.
- `rst` mid-page aborts immediately and returns to IDLE. No `cl_finish` is generated. Partial output is lost.

## Timing
- `page_finish` first sampled high in IDLE at edge T.
- `ram_rd_en` with address 0 is asserted in cycle T+1.
- The FIFO write occurs at T+1+`RD_LAT`. `out_valid` is first high in cycle T+2+`RD_LAT` (T+4 by default).
- Throughput: 1 beat/cycle sustained while `out_ready` is held high.
- When `out_ready` drops, reads stop within one cycle once credit is exhausted. Reads resume the cycle after a pop frees credit.
- `cl_finish` is asserted the cycle after the `out_last` handshake.
- Zero-length page: `cl_finish` is asserted at T+1 and no beats are emitted.

## Configuration
- `CLEAN_OUT_ZERO_FILL_EN`, when defined:
  - Each line read is also written to zero so the banks start clean for the next page.
  - `ram_we` = 1 with `ram_wr_addr` = `ram_rd_addr` delayed `RD_LAT` cycles, coincident with the read-data capture.
- When undefined: `ram_we` and `ram_wr_addr` are tied to 0, and bank contents persist.

## Test plan
- Basic page: `page_len`=256, `out_ready`=1 → 4 beats on consecutive cycles starting T+4, keep all ones, `out_last` on beat 4, `cl_finish` at T+8.
- Partial last beat: `page_len`=100 → 2 beats; the last beat has keep=`0x0000_000F_FFFF_FFFF` (36 bytes) and `out_last`=1.
- Backpressure: `page_len`=1024 with `out_ready` toggling 1-0-0-1 → all 16 lines delivered in address order, no drops or duplicates, and `ram_rd_en` never exceeds credit (FIFO ≤ 4).
- Zero length and retrigger: `page_len`=0 with `page_finish` held high 3 cycles → exactly one `cl_finish` pulse at T+1 and no `out_valid`.
- Reset mid-page: `rst` asserted during beat 3 of 8 → the next cycle has all outputs 0 and no `cl_finish`. A new `page_finish` then restarts cleanly from address 0.
- Zero-fill (macro defined): after a 128-byte page, `ram_we` pulses for lines 0 and 1, and a readback of those lines returns zero.
